// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares one 256x24 synchronous instruction memory between N_CORES fetch
//   requesters and an external program loader. A mode FSM decides who owns
//   the memory: nobody (IDLE, cores held), the loader (LOAD), or the cores
//   through a round-robin arbiter (RUN). Read data comes back one cycle after
//   a transfer and is broadcast; core_rvalid marks the owner.
//
//   Optional build macro: IMEM_ARB_PERF_EN adds grant_count / stall_count.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   core_req/core_addr   per-core fetch request and address (core i at [i*ADDR_W +: ADDR_W])
//   core_gnt             one-hot grant, combinational, RUN only
//   core_rvalid          one-hot, registered, the cycle after a transfer
//   core_rdata           broadcast read data (mem_data_out passthrough)
//   cores_hold           high in IDLE/LOAD
//   load_start/load_done loader session control pulses
//   load_wr/addr/data    loader write port (effective in LOAD only)
//   load_count           words written since last load_start, saturating
//   mem_*                memory address / write enable / write data / read data
//   grant_count          (IMEM_ARB_PERF_EN) RUN transfers, saturating
//   stall_count          (IMEM_ARB_PERF_EN) RUN cycles with a waiting requester
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | after reset; cores held, memory untouched
// LOAD  | loader owns memory; cores held, no grants
// RUN   | cores fetch under round-robin arbitration

module imem_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    output logic [N_CORES-1:0]          core_gnt,
    output logic [N_CORES-1:0]          core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        cores_hold,
    input  logic                        load_start,
    input  logic                        load_wr,
    input  logic [ADDR_W-1:0]           load_addr,
    input  logic [DATA_W-1:0]           load_data,
    input  logic                        load_done,
    output logic [ADDR_W:0]             load_count,
    output logic [ADDR_W-1:0]           mem_address,
    output logic                        mem_write_enable,
    output logic [DATA_W-1:0]           mem_data_in,
    input  logic [DATA_W-1:0]           mem_data_out
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [15:0]                 grant_count,
    output logic [15:0]                 stall_count
`endif
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [ADDR_W:0]  COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [N_CORES-1:0] ONE = {{(N_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   next_ptr;
    logic               found;
    logic               transfer;
    logic [N_CORES-1:0] winner_oh;
    logic [ADDR_W-1:0]  addr_arr [N_CORES];

    // (base + offs) mod N_CORES, offs < N_CORES
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_CORES) sum = sum - N_CORES;
        return PTR_W'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            addr_arr[i] = core_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Search upward from rr_ptr; with no request winner stays at rr_ptr so the
    // idle address output is core_addr[rr_ptr].
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        for (int k = 0; k < N_CORES; k++) begin
            if (!found && core_req[wrap_idx(rr_ptr, k)]) begin
                found  = 1'b1;
                winner = wrap_idx(rr_ptr, k);
            end
        end
    end

    assign transfer  = (state == ST_RUN) && !reset && found;
    assign winner_oh = ONE << winner;
    assign next_ptr  = (winner == PTR_W'(N_CORES - 1)) ? '0 : winner + 1'b1;
    assign core_rdata = mem_data_out;

    always_comb begin
        core_gnt         = '0;
        mem_address      = load_addr;
        mem_data_in      = load_data;
        mem_write_enable = 1'b0;
        if (state == ST_RUN) begin
            mem_address = addr_arr[winner];
            if (transfer) core_gnt = winner_oh;
        end else if (state == ST_LOAD && !reset) begin
            mem_write_enable = load_wr;
        end
    end

    // A transfer on the edge that leaves RUN still completes: rr_ptr and
    // core_rvalid update regardless of the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            load_count  <= '0;
            core_rvalid <= '0;
            cores_hold  <= 1'b1;
        end else begin
            core_rvalid <= transfer ? winner_oh : '0;
            if (transfer) rr_ptr <= next_ptr;

            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        load_count <= '0;
                    end
                end
                ST_LOAD: begin
                    // load_start outranks load_done and any same-cycle write
                    if (load_start) begin
                        load_count <= '0;
                    end else begin
                        if (load_wr && load_count != COUNT_MAX) begin
                            load_count <= load_count + 1'b1;
                        end
                        if (load_done) begin
                            state      <= ST_RUN;
                            cores_hold <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        load_count <= '0;
                        cores_hold <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cores_hold <= 1'b1;
                end
            endcase
        end
    end

`ifdef IMEM_ARB_PERF_EN
    logic stall;

    assign stall = (state == ST_RUN) && !reset && (|(core_req & ~core_gnt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_count <= '0;
            stall_count <= '0;
        end else if (load_start) begin
            grant_count <= '0;
            stall_count <= '0;
        end else begin
            if (transfer && grant_count != 16'hFFFF) grant_count <= grant_count + 1'b1;
            if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 24;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam logic [31:0] CA = 32'h02010200; // core3=02 core2=01 core1=02 core0=00

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_req;
    logic [N*AW-1:0] core_addr;
    logic [N-1:0]    core_gnt;
    logic [N-1:0]    core_rvalid;
    logic [DW-1:0]   core_rdata;
    logic            cores_hold;
    logic            load_start, load_wr, load_done;
    logic [AW-1:0]   load_addr;
    logic [DW-1:0]   load_data;
    logic [AW:0]     load_count;
    logic [AW-1:0]   mem_address;
    logic            mem_write_enable;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;

    always #5 clk = ~clk;

    imem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .cores_hold(cores_hold),
        .load_start(load_start), .load_wr(load_wr), .load_addr(load_addr),
        .load_data(load_data), .load_done(load_done), .load_count(load_count),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Instruction memory: synchronous write, registered read.
    logic [DW-1:0] mem_arr [256];
    always @(posedge clk) begin
        if (mem_write_enable) mem_arr[mem_address] <= mem_data_in;
        mem_data_out <= mem_arr[mem_address];
    end

    // Reference model state
    int            m_mode, m_ptr, m_cnt;
    logic [N-1:0]  m_rv;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [256];

    int errors = 0;
    int checks = 0;

    logic [N-1:0]  o_gnt, o_rv;
    logic [AW-1:0] o_addr;
    logic          o_we, o_hold;
    logic [DW-1:0] o_rdata;
    logic [AW:0]   o_cnt;

    typedef struct {
        logic st, dn, wr;
        logic [7:0] wa;
        logic [23:0] wd;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [7:0] addr;
        logic we;
        logic [3:0] rv;
        logic [23:0] rd;
        logic hold;
        logic [8:0] cnt;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner = requesting core at the smallest rotational distance from ptr.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        int best, bestd, d;
        best = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [7:0] caddr_of(input logic [31:0] ca, input int i);
        return ca[i*8 +: 8];
    endfunction

    function automatic vec_t mk(input int st, dn, wr, wa, wd, req, gnt, addr, we, rv, rd, hold, cnt);
        vec_t v;
        v.st = st[0]; v.dn = dn[0]; v.wr = wr[0];
        v.wa = wa[7:0]; v.wd = wd[23:0]; v.req = req[3:0];
        v.gnt = gnt[3:0]; v.addr = addr[7:0]; v.we = we[0];
        v.rv = rv[3:0]; v.rd = rd[23:0]; v.hold = hold[0]; v.cnt = cnt[8:0];
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_ptr = 0;
        m_cnt = 0;
        m_rv = '0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic st, input logic dn, input logic wr, input logic [7:0] wa,
                         input logic [23:0] wd, input logic [3:0] req, input logic [31:0] ca);
        int w;
        logic [3:0] e_gnt;
        logic [7:0] e_addr;
        logic e_we;
        load_start = st; load_done = dn; load_wr = wr;
        load_addr = wa; load_data = wd; core_req = req; core_addr = ca;
        #1;
        w = (m_mode == M_RUN) ? pick(req, m_ptr) : -1;
        e_gnt = '0;
        if (w >= 0) e_gnt[w] = 1'b1;
        if (m_mode == M_RUN) e_addr = (w >= 0) ? caddr_of(ca, w) : caddr_of(ca, m_ptr);
        else e_addr = wa;
        e_we = (m_mode == M_LOAD) && wr;
        o_gnt = core_gnt; o_addr = mem_address; o_we = mem_write_enable;
        check("gnt", 32'(o_gnt), 32'(e_gnt));
        check("mem_address", 32'(o_addr), 32'(e_addr));
        check("mem_we", 32'(o_we), 32'(e_we));
        if (m_mode != M_RUN) check("mem_data_in", 32'(mem_data_in), 32'(wd));
        @(posedge clk);
        m_rv = '0;
        if (w >= 0) begin
            m_rv[w] = 1'b1;
            m_rdata = ref_mem[caddr_of(ca, w)];
            m_ptr = (w + 1) % N;
        end
        if (m_mode == M_LOAD && wr) begin
            ref_mem[wa] = wd;
            if (!st && m_cnt < 256) m_cnt++;
        end
        if (st) begin
            m_mode = M_LOAD;
            m_cnt = 0;
        end else if (dn && m_mode == M_LOAD) begin
            m_mode = M_RUN;
        end
        #1;
        o_rv = core_rvalid; o_rdata = core_rdata; o_hold = cores_hold; o_cnt = load_count;
        check("rvalid", 32'(o_rv), 32'(m_rv));
        check("hold", 32'(o_hold), 32'(m_mode != M_RUN));
        check("load_count", 32'(o_cnt), 32'(m_cnt));
        if (m_rv != 0) check("rdata", 32'(o_rdata), 32'(m_rdata));
        @(negedge clk);
    endtask

    initial begin
        int ca_of [4] = '{0, 2, 1, 2};
        int rd_of [4] = '{1, 3, 2, 3};
        int w;

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end

        vecs[0] = mk(0,0,1,8'h05,24'hAA,0, 0,8'h05,0, 0,0,1,0);
        vecs[1] = mk(0,1,0,0,0,0,        0,0,0,       0,0,1,0);
        vecs[2] = mk(1,0,0,0,0,0,        0,0,0,       0,0,1,0);
        vecs[3] = mk(0,0,1,0,1,0,        0,0,1,       0,0,1,1);
        vecs[4] = mk(0,0,1,1,2,0,        0,1,1,       0,0,1,2);
        vecs[5] = mk(0,0,1,2,3,0,        0,2,1,       0,0,1,3);
        vecs[6] = mk(0,0,0,0,0,4'hF,     0,0,0,       0,0,1,3);
        vecs[7] = mk(0,1,0,0,0,0,        0,0,0,       0,0,0,3);
        vecs[8] = mk(0,0,0,0,0,4'h4,     4'h4,1,0,    4'h4,2,0,3);
        vecs[9] = mk(0,0,0,0,0,4'h8,     4'h8,2,0,    4'h8,3,0,3);
        for (int k = 0; k < 8; k++) begin
            vecs[10+k] = mk(0,0,0,0,0,4'hF, 1 << (k%4), ca_of[k%4], 0, 1 << (k%4), rd_of[k%4], 0, 3);
        end
        vecs[18] = mk(0,0,0,0,0,4'h4,    4'h4,1,0,    4'h4,2,0,3);
        vecs[19] = mk(0,0,0,0,0,4'hA,    4'h8,2,0,    4'h8,3,0,3);
        vecs[20] = mk(0,0,0,0,0,4'hA,    4'h2,2,0,    4'h2,3,0,3);
        vecs[21] = mk(0,0,0,0,0,4'hA,    4'h8,2,0,    4'h8,3,0,3);
        vecs[22] = mk(0,0,0,0,0,0,       0,0,0,       0,0,0,3);
        vecs[23] = mk(0,0,0,0,0,4'h2,    4'h2,2,0,    4'h2,3,0,3);
        vecs[24] = mk(0,0,0,0,0,0,       0,1,0,       0,0,0,3);
        vecs[25] = mk(0,0,0,0,0,4'h1,    4'h1,0,0,    4'h1,1,0,3);
        vecs[26] = mk(0,0,0,0,0,4'h1,    4'h1,0,0,    4'h1,1,0,3);

        // Reset
        reset = 1'b1;
        load_start = 0; load_done = 0; load_wr = 0; load_addr = '0; load_data = '0;
        core_req = '0; core_addr = CA;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", 32'(core_rvalid), 32'h0);
        check("rst_hold", 32'(cores_hold), 32'h1);
        check("rst_count", 32'(load_count), 32'h0);
        core_req = 4'hF;
        #1;
        check("rst_gnt", 32'(core_gnt), 32'h0);
        check("rst_we", 32'(mem_write_enable), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table: load, single fetch, round robin, skip/wrap, idle address
        for (int i = 0; i < 27; i++) begin
            cycle(vecs[i].st, vecs[i].dn, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].req, CA);
            check($sformatf("tbl%0d_gnt", i), 32'(o_gnt), 32'(vecs[i].gnt));
            check($sformatf("tbl%0d_addr", i), 32'(o_addr), 32'(vecs[i].addr));
            check($sformatf("tbl%0d_we", i), 32'(o_we), 32'(vecs[i].we));
            check($sformatf("tbl%0d_rv", i), 32'(o_rv), 32'(vecs[i].rv));
            check($sformatf("tbl%0d_hold", i), 32'(o_hold), 32'(vecs[i].hold));
            check($sformatf("tbl%0d_cnt", i), 32'(o_cnt), 32'(vecs[i].cnt));
            if (vecs[i].rv != 0) check($sformatf("tbl%0d_rdata", i), 32'(o_rdata), 32'(vecs[i].rd));
        end

        // Mode switch with a core 0 transfer on the switching edge (rr_ptr=1)
        cycle(1, 0, 0, 0, 0, 4'h1, CA);
        check("sw_gnt", 32'(o_gnt), 32'h1);
        check("sw_rv_in_load", 32'(o_rv), 32'h1);
        check("sw_rdata", 32'(o_rdata), 32'h1);
        check("sw_hold", 32'(o_hold), 32'h1);
        cycle(0, 0, 0, 0, 0, 4'h1, CA);
        check("load_no_gnt", 32'(o_gnt), 32'h0);
        check("load_no_rv", 32'(o_rv), 32'h0);
        cycle(1, 1, 0, 0, 0, 4'h1, CA);
        check("start_beats_done", 32'(o_hold), 32'h1);
        cycle(0, 1, 0, 0, 0, 4'h0, CA);
        check("done_to_run", 32'(o_hold), 32'h0);

        // load_count saturation
        cycle(1, 0, 0, 0, 0, 4'h0, CA);
        for (int i = 0; i < 300; i++) begin
            cycle(0, 0, 1, 8'($urandom), 24'($urandom), 4'($urandom), $urandom);
        end
        check("count_sat", 32'(o_cnt), 32'd256);
        cycle(0, 1, 0, 0, 0, 4'h0, CA);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
                  8'($urandom), 24'($urandom), 4'($urandom), $urandom);
        end

        // Async reset before a pending grant's edge
        cycle(0, 1, 0, 0, 0, 4'h0, CA);
        core_req = 4'h2; core_addr = CA;
        #1;
        w = pick(4'h2, m_ptr);
        check("pre_rst_gnt", 32'(core_gnt), 32'(1 << w));
        #2 reset = 1'b1;
        #1;
        check("rst_gnt_now", 32'(core_gnt), 32'h0);
        check("rst_we_now", 32'(mem_write_enable), 32'h0);
        check("rst_hold_now", 32'(cores_hold), 32'h1);
        @(posedge clk);
        #1 check("rst_no_rv", 32'(core_rvalid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Async reset after the transfer edge, while rvalid is pending
        cycle(1, 0, 0, 0, 0, 4'h0, CA);
        cycle(0, 1, 0, 0, 0, 4'h0, CA);
        core_req = 4'h2; core_addr = CA;
        @(posedge clk);
        #2 check("rv_before_rst", 32'(core_rvalid), 32'h2);
        reset = 1'b1;
        #1 check("rv_cleared", 32'(core_rvalid), 32'h0);
        check("rst_hold2", 32'(cores_hold), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(0, 1, 1, 8'h10, 24'h123456, 4'hF, CA);
        check("idle_ignores_done", 32'(o_hold), 32'h1);
        check("idle_no_we", 32'(o_we), 32'h0);
        check("idle_no_gnt", 32'(o_gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single 256x24 synchronous instruction memory among N cores of the multiprocessor build, plus one external program loader.
- Sequences memory ownership with a mode FSM:
  - IDLE: cores held.
  - LOAD: loader owns memory.
  - RUN: round-robin core fetch.
- Drives the memory's address, write_enable and data_in, and routes data_out back to the granted core with 1-cycle read latency.

Parameters:
- N_CORES, 4, number of fetch requesters (2..8).
- ADDR_W, 8, memory address width.
- DATA_W, 24, instruction width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  N_CORES  per-core fetch request (valid).
- core_addr  in  N_CORES*ADDR_W  per-core fetch address; core i at bits [i*ADDR_W +: ADDR_W].
- core_gnt  out  N_CORES  one-hot ready; a transfer occurs at a posedge where req[i] & gnt[i].
- core_rvalid  out  N_CORES  one-hot; high the cycle after core i's transfer.
- core_rdata  out  DATA_W  broadcast read data; equals mem_data_out.
- cores_hold  out  1  high in IDLE/LOAD; cores must stay stalled.
- load_start  in  1  pulse; enter LOAD.
- load_wr  in  1  loader write strobe (LOAD only).
- load_addr  in  ADDR_W  loader write address.
- load_data  in  DATA_W  loader write data.
- load_done  in  1  pulse; leave LOAD for RUN.
- load_count  out  ADDR_W+1  words written since last load_start.
- mem_address  out  ADDR_W  to memory address.
- mem_write_enable  out  1  to memory write_enable.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out (registered in memory).

Behaviour:
- Reset (async):
  - state=IDLE, rr_ptr=0, load_count=0, core_rvalid=0, cores_hold=1.
  - core_gnt=0 and mem_write_enable=0 while reset is high.
- FSM:
  - IDLE: load_start -> LOAD; load_done is ignored.
  - LOAD:
    - load_done -> RUN.
    - load_start restarts load_count=0 and stays in LOAD.
    - If load_start and load_done are high together, load_start wins.
  - RUN: load_start -> LOAD.
- IDLE and LOAD:
  - core_gnt=0.
  - mem_address=load_addr, mem_data_in=load_data.
  - mem_write_enable=load_wr only in LOAD; 0 in IDLE.
- Loader writes:
  - Each load_wr posedge in LOAD increments load_count.
  - load_count saturates at 256.
  - load_wr outside LOAD is ignored.
- RUN arbitration (combinational, same cycle):
  - Winner = first i with core_req[i]=1, searching from rr_ptr upward modulo N_CORES.
  - core_gnt[winner]=1; mem_address=core_addr[winner]; mem_write_enable=0.
  - With no requests: core_gnt=0 and mem_address=core_addr[rr_ptr].
- On a transfer: rr_ptr <= (winner+1) mod N_CORES; core_rvalid <= onehot(winner).
  - Otherwise core_rvalid <= 0.
- Throughput:
  - One fetch per cycle.
  - A lone requester is granted every cycle; back-to-back grants return back-to-back rvalids.
- Fairness: with all N requesting continuously, each core is granted exactly once per N cycles.
- RUN->LOAD switch:
  - The transfer at the switching edge completes; its rvalid is still delivered in the first LOAD cycle.
  - No grants are issued in LOAD.
- Mid-operation reset clears a pending rvalid; no data is delivered.
- mem_data_out is passed through unregistered; core_rdata is meaningful only with core_rvalid.

Optional Feature:
- Macro: IMEM_ARB_PERF_EN.
- When defined, adds the following outputs:
  - grant_count (16 bits): total RUN transfers, saturating at 0xFFFF.
  - stall_count (16 bits): RUN cycles with at least one core_req high and not granted, counted per cycle, saturating.
- Both counters are cleared by reset and by load_start.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset/load:
  - Stimulus: reset, then load_start, then 3 load_wr to addr 0..2 with 0x000001..0x000003, then load_done.
  - Required: load_count=3, mem_write_enable pulses 3 times, cores_hold goes 1->0 after load_done, state RUN.
- Single fetch:
  - Stimulus: RUN, core 2 requests addr 0x01.
  - Required: core_gnt=0b0100 the same cycle; next cycle core_rvalid=0b0100 and core_rdata=0x000002.
- Round-robin:
  - Stimulus: all 4 cores request continuously for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; each core_rvalid follows its grant by 1 cycle.
- Skip/wrap:
  - Stimulus: rr_ptr=3, only cores 1 and 3 request.
  - Required: grant 3, then 1, then 3.
- Mode switch:
  - Stimulus: load_start at the same edge as a core 0 transfer.
  - Required: core_rvalid[0]=1 in the first LOAD cycle; core_gnt stays 0 while core_req stays high; cores_hold=1.
- Async reset mid-fetch:
  - Stimulus: assert reset between a grant and its rvalid.
  - Required: core_rvalid=0 immediately; state IDLE; mem_write_enable=0.
